// File: rtl/apb4_cpuif_bridge.sv
// APB4 completer that turns each APB transfer into a single-cycle CPU-interface request,
// stretching the access phase until the register block acks or a wait-state timeout expires.
module apb4_cpuif_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_apb_psel,
    input  logic                    s_apb_penable,
    input  logic                    s_apb_pwrite,
    input  logic [2:0]              s_apb_pprot,
    input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
    output logic                    s_apb_pready,
    output logic [DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                    s_apb_pslverr,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << ADDR_LSB) - 1);
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   biten_q, biten_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic                    pready_q, pready_d;
    logic [7:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   strb_bits;
    logic                    ack_match;
    logic                    ack_err;

    // Protection attributes carry no meaning for the register block.
    logic unused_pprot;
    assign unused_pprot = ^s_apb_pprot;

    always_comb begin
        strb_bits = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            strb_bits[i*8 +: 8] = {8{s_apb_pstrb[i]}};
        end
    end

    // Only the ack matching the captured direction can end the transfer.
    assign ack_match = is_wr_q ? cpuif_wr_ack : cpuif_rd_ack;
    assign ack_err   = is_wr_q ? cpuif_wr_err : cpuif_rd_err;

    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        pready_d  = 1'b0;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        biten_d   = biten_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (s_apb_psel && !s_apb_penable) begin
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    is_wr_d   = s_apb_pwrite;
                    addr_d    = s_apb_paddr & ADDR_MASK;
                    wr_data_d = s_apb_pwdata;
                    biten_d   = s_apb_pwrite ? strb_bits : '0;
                    count_d   = '0;
                end
            end
            S_REQ, S_WAIT: begin
                if (ack_match) begin
                    state_d   = S_DONE;
                    pready_d  = 1'b1;
                    prdata_d  = is_wr_q ? '0 : cpuif_rd_data;
                    pslverr_d = ack_err;
                end else if (state_q == S_WAIT && count_q == COUNT_LAST) begin
                    state_d   = S_DONE;
                    pready_d  = 1'b1;
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    if (state_q == S_WAIT) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            biten_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            biten_q   <= biten_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
            count_q   <= count_d;
        end
    end

    assign s_apb_pready    = pready_q;
    assign s_apb_prdata    = prdata_q;
    assign s_apb_pslverr   = pslverr_q;
    assign cpuif_req       = req_q;
    assign cpuif_req_is_wr = is_wr_q;
    assign cpuif_addr      = addr_q;
    assign cpuif_wr_data   = wr_data_q;
    assign cpuif_wr_biten  = biten_q;

endmodule

// File: tb/tb_apb4_cpuif_bridge.sv
// Scoreboard bench: stimulus queues expected requests/responses from a word-memory model,
// monitors pop and compare whenever the DUT pulses cpuif_req or s_apb_pready.
module tb_apb4_cpuif_bridge;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;
    localparam int NO_ACK = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]    pprot = '0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          req, req_is_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wr_data, req_biten;
    logic          rd_ack = 1'b0, rd_err = 1'b0, wr_ack = 1'b0, wr_err = 1'b0;
    logic [DW-1:0] rd_data = '0;

    apb4_cpuif_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
        .cpuif_req(req), .cpuif_req_is_wr(req_is_wr), .cpuif_addr(req_addr),
        .cpuif_wr_data(req_wr_data), .cpuif_wr_biten(req_biten),
        .cpuif_rd_ack(rd_ack), .cpuif_rd_err(rd_err), .cpuif_rd_data(rd_data),
        .cpuif_wr_ack(wr_ack), .cpuif_wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] biten;
    } req_t;

    typedef struct {
        logic [DW-1:0] prdata;
        logic          slverr;
        int            cyc;
        logic [AW-1:0] addr;
    } resp_t;

    req_t  exp_req_q[$];
    resp_t exp_resp_q[$];
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] reg_mem [8];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int req_count = 0;

    int            cfg_delay = 0;
    logic          cfg_err = 1'b0;
    logic          cfg_spurious = 1'b0;
    logic          cfg_override = 1'b0;
    logic [DW-1:0] cfg_rd_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Request and response monitors: every DUT output event must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (req) begin
                req_count++;
                if (exp_req_q.size() == 0) begin
                    checkOutput("unexpected_req", 1, 0);
                end else begin
                    req_t e;
                    e = exp_req_q.pop_front();
                    checkOutput("req_is_wr", req_is_wr, e.is_wr);
                    checkOutput("req_addr", req_addr, e.addr);
                    checkOutput("req_biten", req_biten, e.biten);
                    if (e.is_wr) checkOutput("req_wr_data", req_wr_data, e.wdata);
                end
            end
            if (pready) begin
                if (exp_resp_q.size() == 0) begin
                    checkOutput("unexpected_pready", 1, 0);
                end else begin
                    resp_t r;
                    r = exp_resp_q.pop_front();
                    checkOutput("prdata", prdata, r.prdata);
                    checkOutput("pslverr", pslverr, r.slverr);
                    checkOutput("pready_cycle", cyc, r.cyc);
                    checkOutput("addr_held", req_addr, r.addr);
                end
            end
        end
    end

    // Register-block stand-in: acks after cfg_delay cycles, backed by its own word memory.
    always begin
        @(negedge clk);
        if (req && !rst) begin
            logic          is_wr, aborted;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, be;
            int            d;
            is_wr = req_is_wr; a = req_addr; wd = req_wr_data; be = req_biten;
            d = cfg_delay; aborted = 1'b0;
            if (d == NO_ACK) begin
                aborted = 1'b1;
            end else if (cfg_spurious && d > 0) begin
                if (is_wr) begin rd_ack = 1'b1; rd_err = 1'b1; rd_data = $urandom; end
                else begin wr_ack = 1'b1; wr_err = 1'b1; end
            end
            for (int i = 0; i < d && !aborted; i++) begin
                @(posedge clk); #1;
                rd_ack = 1'b0; wr_ack = 1'b0; rd_err = 1'b0; wr_err = 1'b0;
                @(negedge clk);
                if (rst) aborted = 1'b1;
            end
            if (!aborted) begin
                if (is_wr) begin
                    wr_ack = 1'b1; wr_err = cfg_err;
                    reg_mem[a[4:2]] = (reg_mem[a[4:2]] & ~be) | (wd & be);
                end else begin
                    rd_ack = 1'b1; rd_err = cfg_err;
                    rd_data = cfg_override ? cfg_rd_data : reg_mem[a[4:2]];
                end
            end
            @(posedge clk); #1;
            rd_ack = 1'b0; wr_ack = 1'b0; rd_err = 1'b0; wr_err = 1'b0;
        end
    end

    function automatic logic [DW-1:0] expandStrb(input logic [3:0] s);
        logic [DW-1:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) if (s[i]) b[i*8 +: 8] = 8'hFF;
        return b;
    endfunction

    // Issues one APB transfer starting in the current cycle (called just after a rising edge).
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [3:0] strb, input int delay, input logic err,
                                 input logic spurious, input logic use_override, input logic [DW-1:0] ovr);
        req_t  r;
        resp_t p;
        logic  acked;
        int    budget;
        cfg_delay = delay; cfg_err = err; cfg_spurious = spurious;
        cfg_override = use_override; cfg_rd_data = ovr;
        acked = (delay != NO_ACK) && (delay < TO);
        r.is_wr = wr; r.addr = {addr[4:2], 2'b00}; r.wdata = wdata;
        r.biten = wr ? expandStrb(strb) : '0;
        exp_req_q.push_back(r);
        p.addr = r.addr;
        if (acked) begin
            p.prdata = wr ? '0 : (use_override ? ovr : ref_mem[addr[4:2]]);
            p.slverr = err;
            p.cyc    = cyc + 2 + delay;
            if (wr) ref_mem[addr[4:2]] = (ref_mem[addr[4:2]] & ~r.biten) | (wdata & r.biten);
        end else begin
            p.prdata = '0;
            p.slverr = 1'b1;
            p.cyc    = cyc + 2 + TO;
        end
        exp_resp_q.push_back(p);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        pprot = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        penable = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!pready && budget < TO + 10);
        if (!pready) begin
            checkOutput("pready_wait_expired", 0, 1);
            exp_req_q.delete(); exp_resp_q.delete();
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pready"}, pready, 0);
        checkOutput({tag, "_prdata"}, prdata, 0);
        checkOutput({tag, "_pslverr"}, pslverr, 0);
        checkOutput({tag, "_req"}, req, 0);
        checkOutput({tag, "_is_wr"}, req_is_wr, 0);
        checkOutput({tag, "_addr"}, req_addr, 0);
        checkOutput({tag, "_wr_data"}, req_wr_data, 0);
        checkOutput({tag, "_biten"}, req_biten, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            base;
        logic [DW-1:0] held;
        for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; reg_mem[i] = '0; end
        #3;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 5'h06, 32'hA5A5_1234, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 5'h08, '0, 4'h0, 3, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 5'h0C, 32'h1122_3344, 4'h5, 1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 5'h0C, '0, 4'h0, 2, 1'b0, 1'b1, 1'b0, '0);

        // Timeout with an ack arriving two cycles after the completion.
        applyStimulus(1'b0, 5'h10, '0, 4'h0, 19, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
        base = req_count; held = prdata;
        repeat (5) @(posedge clk); #1;
        checkOutput("late_ack_req_count", req_count, base);
        checkOutput("late_ack_prdata", prdata, held);

        // Reset pulsed during WAIT.
        cfg_delay = 5; cfg_err = 1'b0; cfg_spurious = 1'b0; cfg_override = 1'b0;
        exp_req_q.push_back('{1'b1, 5'h10, 32'hCAFE_F00D, 32'hFFFF_FFFF});
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h10; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #2 checkResetOutputs("midrst");
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        applyStimulus(1'b1, 5'h14, 32'h0BAD_CAFE, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0);

        base = req_count;
        applyStimulus(1'b1, 5'h00, 32'h1357_9BDF, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 5'h00, '0, 4'h0, 0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 5'h04, 32'h2468_ACE0, 4'hF, 0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 5'h04, '0, 4'h0, 0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("b2b_req_count", req_count, base + 4);

        for (int n = 0; n < 40; n++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? NO_ACK : $urandom_range(0, TO - 1);
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          4'($urandom_range(0, 15)), d, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        checkOutput("req_queue_drained", exp_req_q.size(), 0);
        checkOutput("resp_queue_drained", exp_resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
